// File: rtl/rat_io_bridge.sv
// Port-mapped I/O bridge for the RAT MCU: N_IN read ports, N_OUT registered write ports with
// per-port write pulses, and an N_IRQ-source edge-triggered interrupt controller.
module rat_io_bridge #(
  parameter int unsigned          DATA_W       = 8,
  parameter int unsigned          N_IN         = 4,
  parameter int unsigned          N_OUT        = 4,
  parameter int unsigned          N_IRQ        = 4,
  parameter logic [N_IN*8-1:0]    IN_IDS       = {8'h96, 8'h40, 8'h20, 8'hFF},
  parameter logic [N_OUT*8-1:0]   OUT_IDS      = {8'h42, 8'h41, 8'h69, 8'h81},
  parameter logic [7:0]           IRQ_MASK_ID  = 8'hE0,
  parameter logic [7:0]           IRQ_PEND_ID  = 8'hE1,
  parameter bit                   OUT_READBACK = 1'b1,
  parameter bit                   INTR_MODE    = 1'b0
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [7:0]              PORT_ID,
  input  logic [DATA_W-1:0]       OUT_PORT,
  input  logic                    IO_STRB,
  output logic [DATA_W-1:0]       IN_PORT,
  output logic                    INTR,
  input  logic [N_IN*DATA_W-1:0]  in_data,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_wr,
  input  logic [N_IRQ-1:0]        irq_src
);

  logic [N_OUT*DATA_W-1:0] r_out_data;
  logic [N_OUT-1:0]        r_out_wr;
  logic [N_IRQ-1:0]        r_mask;
  logic [N_IRQ-1:0]        r_pend;
  logic [N_IRQ-1:0]        r_s1, r_s2, r_s3;

  logic [N_OUT-1:0]        w_out_hit;
  logic                    w_mask_wr;
  logic [N_IRQ-1:0]        w_pend_clr;
  logic [N_IRQ-1:0]        w_edge;
  logic [N_IRQ-1:0]        w_active;
  logic [DATA_W-1:0]       w_rd;
  logic                    w_found;

  always_comb begin
    for (int unsigned i = 0; i < N_OUT; i++) begin
      w_out_hit[i] = IO_STRB && (PORT_ID == OUT_IDS[8*i +: 8]);
    end
  end

  assign w_mask_wr  = IO_STRB && (PORT_ID == IRQ_MASK_ID);
  assign w_pend_clr = (IO_STRB && (PORT_ID == IRQ_PEND_ID)) ? OUT_PORT[N_IRQ-1:0] : '0;
  assign w_edge     = r_s2 & ~r_s3;
  assign w_active   = r_pend & r_mask;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_out_data <= '0;
      r_out_wr   <= '0;
      r_mask     <= '0;
      r_pend     <= '0;
      r_s1       <= '0;
      r_s2       <= '0;
      r_s3       <= '0;
    end else begin
      for (int unsigned i = 0; i < N_OUT; i++) begin
        if (w_out_hit[i]) r_out_data[DATA_W*i +: DATA_W] <= OUT_PORT;
      end
      r_out_wr <= w_out_hit;
      if (w_mask_wr) r_mask <= OUT_PORT[N_IRQ-1:0];
      // OR-ing the edge in after the clear lets a new event win over a simultaneous W1C.
      r_pend <= (r_pend & ~w_pend_clr) | w_edge;
      r_s1   <= irq_src;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
    end
  end

  // Read mux: mask, pending, lowest matching input, then lowest matching output readback.
  always_comb begin
    w_rd    = '0;
    w_found = 1'b0;
    if (PORT_ID == IRQ_MASK_ID) begin
      w_rd[N_IRQ-1:0] = r_mask;
    end else if (PORT_ID == IRQ_PEND_ID) begin
      w_rd[N_IRQ-1:0] = r_pend;
    end else begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (!w_found && (PORT_ID == IN_IDS[8*i +: 8])) begin
          w_rd    = in_data[DATA_W*i +: DATA_W];
          w_found = 1'b1;
        end
      end
      if (OUT_READBACK) begin
        for (int unsigned j = 0; j < N_OUT; j++) begin
          if (!w_found && (PORT_ID == OUT_IDS[8*j +: 8])) begin
            w_rd    = r_out_data[DATA_W*j +: DATA_W];
            w_found = 1'b1;
          end
        end
      end
    end
  end

  generate
    if (INTR_MODE) begin : g_intr_pulse
      logic [N_IRQ-1:0] r_prev;
      logic             r_intr;
      always_ff @(posedge CLK) begin
        if (RESET) begin
          r_prev <= '0;
          r_intr <= 1'b0;
        end else begin
          r_prev <= w_active;
          r_intr <= |(w_active & ~r_prev);
        end
      end
      assign INTR = r_intr;
    end else begin : g_intr_level
      assign INTR = |w_active;
    end
  endgenerate

  assign IN_PORT  = w_rd;
  assign out_data = r_out_data;
  assign out_wr   = r_out_wr;

endmodule

// File: tb/tb_rat_io_bridge.sv
// Self-checking bench for rat_io_bridge: a level-INTR and a pulse-INTR instance share stimulus.
module tb_rat_io_bridge;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IO_STRB;
  logic [7:0]  PORT_ID;
  logic [7:0]  OUT_PORT;
  logic [31:0] in_data;
  logic [3:0]  irq_src;

  logic [7:0]  in_port_l, in_port_p;
  logic        intr_l, intr_p;
  logic [31:0] out_data_l, out_data_p;
  logic [3:0]  out_wr_l, out_wr_p;

  always #5 CLK = ~CLK;

  rat_io_bridge #(.INTR_MODE(1'b0)) dut_l (
    .CLK(CLK), .RESET(RESET), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB),
    .IN_PORT(in_port_l), .INTR(intr_l), .in_data(in_data), .out_data(out_data_l),
    .out_wr(out_wr_l), .irq_src(irq_src)
  );

  rat_io_bridge #(.INTR_MODE(1'b1)) dut_p (
    .CLK(CLK), .RESET(RESET), .PORT_ID(PORT_ID), .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB),
    .IN_PORT(in_port_p), .INTR(intr_p), .in_data(in_data), .out_data(out_data_p),
    .out_wr(out_wr_p), .irq_src(irq_src)
  );

  typedef struct {
    logic [7:0] id;
    logic [7:0] exp;
  } vec_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] sb_q[$];
  vec_t       vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] d);
    PORT_ID  = id;
    OUT_PORT = d;
    IO_STRB  = 1'b1;
    cyc();
    IO_STRB  = 1'b0;
  endtask

  task automatic chk_pend(input string name, input logic [7:0] exp);
    PORT_ID = 8'hE1;
    #1;
    chk(name, in_port_l, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    logic [7:0] e;

    RESET = 1'b1; IO_STRB = 1'b1; PORT_ID = 8'h81; OUT_PORT = 8'hAA;
    in_data = '0; irq_src = '0;

    // Reset beats a concurrent strobe.
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rst_out_data", out_data_l, 32'h0);
      chk("rst_out_wr", {28'h0, out_wr_l}, 32'h0);
      chk("rst_intr_l", {31'h0, intr_l}, 32'h0);
      chk("rst_intr_p", {31'h0, intr_p}, 32'h0);
    end
    RESET = 1'b0;
    cyc();
    chk("wr0_data", out_data_l, 32'h0000_00AA);
    chk("wr0_pulse", {28'h0, out_wr_l}, 32'h1);
    IO_STRB = 1'b0;
    cyc();
    chk("wr0_pulse_end", {28'h0, out_wr_l}, 32'h0);
    chk("wr0_hold", out_data_l, 32'h0000_00AA);

    // Held strobe: pulse stays high for every strobed cycle.
    PORT_ID = 8'h42; OUT_PORT = 8'h77; IO_STRB = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("held_wr_%0d", i), {28'h0, out_wr_l}, 32'h8);
    end
    IO_STRB = 1'b0;
    cyc();
    chk("held_wr_end", {28'h0, out_wr_l}, 32'h0);
    chk("held_wr_data", {24'h0, out_data_l[31:24]}, 32'h77);

    // Read mux table through the scoreboard.
    in_data = {8'h3A, 8'h22, 8'h11, 8'h5C};
    wr(8'h69, 8'h12);
    vecs[0]  = '{id: 8'hFF, exp: 8'h5C};
    vecs[1]  = '{id: 8'h96, exp: 8'h3A};
    vecs[2]  = '{id: 8'h40, exp: 8'h22};
    vecs[3]  = '{id: 8'h20, exp: 8'h11};
    vecs[4]  = '{id: 8'h69, exp: 8'h12};
    vecs[5]  = '{id: 8'h81, exp: 8'hAA};
    vecs[6]  = '{id: 8'h42, exp: 8'h77};
    vecs[7]  = '{id: 8'h41, exp: 8'h00};
    vecs[8]  = '{id: 8'h77, exp: 8'h00};
    vecs[9]  = '{id: 8'hE0, exp: 8'h00};
    vecs[10] = '{id: 8'hE1, exp: 8'h00};
    for (int i = 0; i < 11; i++) begin
      PORT_ID = vecs[i].id;
      sb_q.push_back(vecs[i].exp);
      #1;
      e = sb_q.pop_front();
      chk($sformatf("rdmux_%02h_l", vecs[i].id), {24'h0, in_port_l}, {24'h0, e});
      chk($sformatf("rdmux_%02h_p", vecs[i].id), {24'h0, in_port_p}, {24'h0, e});
      cyc();
    end

    // IRQ latency: rise before edge k, pending/INTR after edge k+2, pulse after k+3.
    wr(8'hE0, 8'h02);
    PORT_ID = 8'hE1;
    irq_src = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk($sformatf("irq_lat_pend_k%0d", k), {24'h0, in_port_l}, 32'h0);
      chk($sformatf("irq_lat_intr_k%0d", k), {31'h0, intr_l}, 32'h0);
    end
    cyc();
    chk("irq_lat_pend_k2", {24'h0, in_port_l}, 32'h02);
    chk("irq_lat_intr_k2", {31'h0, intr_l}, 32'h1);
    chk("irq_pulse_k2", {31'h0, intr_p}, 32'h0);
    cyc();
    chk("irq_pulse_k3", {31'h0, intr_p}, 32'h1);
    cyc();
    chk("irq_pulse_k4", {31'h0, intr_p}, 32'h0);
    pulses = 0;
    repeat (20) begin
      cyc();
      if (intr_p) pulses++;
    end
    chk("irq_held_pulses", pulses, 0);
    chk("irq_held_pend", {24'h0, in_port_l}, 32'h02);
    wr(8'hE1, 8'h02);
    chk("irq_w1c_pend", {24'h0, in_port_l}, 32'h0);
    chk("irq_w1c_intr", {31'h0, intr_l}, 32'h0);
    cyc();
    chk("irq_w1c_no_reedge", {24'h0, in_port_l}, 32'h0);
    irq_src = 4'b0000;

    // Masked source still latches; unmasking raises INTR.
    wr(8'hE0, 8'h00);
    irq_src = 4'b1000;
    cyc(); cyc();
    irq_src = 4'b0000;
    cyc(); cyc(); cyc();
    chk_pend("masked_pend", 8'h08);
    chk("masked_intr_l", {31'h0, intr_l}, 32'h0);
    chk("masked_intr_p", {31'h0, intr_p}, 32'h0);
    wr(8'hE0, 8'h08);
    chk("unmask_intr_l", {31'h0, intr_l}, 32'h1);
    chk("unmask_intr_p0", {31'h0, intr_p}, 32'h0);
    cyc();
    chk("unmask_intr_p1", {31'h0, intr_p}, 32'h1);
    wr(8'hE1, 8'hFF);
    chk("unmask_clr_intr", {31'h0, intr_l}, 32'h0);

    // Set/clear collision on bit 0: set wins.
    irq_src = 4'b0001;
    cyc(); cyc();
    PORT_ID = 8'hE1; OUT_PORT = 8'h01; IO_STRB = 1'b1;
    cyc();
    IO_STRB = 1'b0;
    #1;
    chk("collide_pend", {24'h0, in_port_l}, 32'h01);
    wr(8'hE1, 8'h01);
    chk("collide_clr", {24'h0, in_port_l}, 32'h00);
    irq_src = 4'b0000;

    // Pulse mode: two simultaneous sources -> one pulse; a later source -> another.
    wr(8'hE0, 8'h0F);
    wr(8'hE1, 8'hFF);
    repeat (4) cyc();
    chk("pm_idle", {31'h0, intr_p}, 32'h0);
    irq_src = 4'b0110;
    cyc(); cyc(); cyc();
    chk("pm_k2", {31'h0, intr_p}, 32'h0);
    chk_pend("pm_pend", 8'h06);
    cyc();
    chk("pm_k3", {31'h0, intr_p}, 32'h1);
    pulses = 0;
    repeat (6) begin
      cyc();
      if (intr_p) pulses++;
    end
    chk("pm_single_pulse", pulses, 0);
    irq_src = 4'b0111;
    cyc(); cyc(); cyc();
    chk("pm2_k2", {31'h0, intr_p}, 32'h0);
    cyc();
    chk("pm2_k3", {31'h0, intr_p}, 32'h1);
    cyc();
    chk("pm2_k4", {31'h0, intr_p}, 32'h0);
    chk_pend("pm2_pend", 8'h07);
    chk("pm2_level", {31'h0, intr_l}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
